// File: rtl/eret_pkg.sv
// Shared definitions for the exception-return controller: FSM encoding,
// default reset EPC and the word-alignment mask applied to every EPC write.
package eret_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } eret_state_e;

    localparam logic [31:0] ERET_RESET_EPC = 32'h0000_3000;
    localparam logic [31:0] EPC_ALIGN_MASK = 32'hFFFF_FFFC;

    // EPC always holds a word address.
    function automatic logic [31:0] epc_align(input logic [31:0] v);
        return v & EPC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/eret_drain_cnt.sv
// 4-bit loadable down-counter that times the pipeline drain after an ERET
// flush. done flags the last drain cycle (count==1).
module eret_drain_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [3:0] count;

    // Load takes precedence over decrement; the count floors at zero.
    always_ff @(posedge clk) begin
        if (!reset)
            count <= 4'd0;
        else if (load)
            count <= load_val;
        else if (dec && count != 4'd0)
            count <= count - 4'd1;
    end

    assign done = (count == 4'd1);

endmodule

// File: rtl/eret_ctrl.sv
// Exception-return controller: owns EPC and EXL, and on a retiring ERET
// flushes, drains and then redirects fetch to the saved EPC.
// Optional feature: define ERET_CNT_EN to add eret_count, a saturating
// count of completed redirect handshakes.
module eret_ctrl
    import eret_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [31:0] RESET_EPC    = ERET_RESET_EPC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_req,
    input  logic [31:0] exc_epc,
    input  logic        epc_we,
    input  logic [31:0] epc_wdata,
    input  logic        eret_req,
    input  logic        redir_ready,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        exl,
    output logic [31:0] epc,
    output logic        eret_err
`ifdef ERET_CNT_EN
    ,
    output logic [31:0] eret_count
`endif
);

    localparam logic [3:0] DRAIN_LD   = 4'(DRAIN_CYCLES);
    localparam logic       SKIP_DRAIN = (DRAIN_CYCLES == 0);

    eret_state_e state;
    logic        exc_take;
    logic        eret_go;
    logic        eret_bad;
    logic        hs;
    logic        drain_done;

    // Exceptions never nest; an exception in the ERET cycle wins and the
    // ERET is silently dropped. Nothing new starts outside IDLE.
    assign exc_take = exc_req && !exl;
    assign eret_go  = (state == IDLE) && eret_req && exl && !exc_req;
    assign eret_bad = (state == IDLE) && eret_req && !exl && !exc_req;
    assign hs       = (state == REDIRECT) && redir_valid && redir_ready;

    eret_drain_cnt u_drain (
        .clk      (clk),
        .reset    (reset),
        .load     (eret_go),
        .load_val (DRAIN_LD),
        .dec      (state == DRAIN),
        .done     (drain_done)
    );

    // EPC and EXL: exception entry beats an MTC0 write; the handshake ends EXL.
    always_ff @(posedge clk) begin
        if (!reset) begin
            epc <= RESET_EPC;
            exl <= 1'b0;
        end else begin
            if (exc_take)
                epc <= epc_align(exc_epc);
            else if (epc_we)
                epc <= epc_align(epc_wdata);

            if (exc_take)
                exl <= 1'b1;
            else if (hs)
                exl <= 1'b0;
        end
    end

    // Return FSM with registered strobes; redir_pc is latched once at accept
    // so later EPC writes cannot disturb an in-flight redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            redir_pc    <= 32'd0;
            redir_valid <= 1'b0;
            flush       <= 1'b0;
            stall       <= 1'b0;
            busy        <= 1'b0;
            eret_err    <= 1'b0;
        end else begin
            flush    <= 1'b0;
            eret_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (eret_go) begin
                        redir_pc <= epc;
                        flush    <= 1'b1;
                        stall    <= 1'b1;
                        busy     <= 1'b1;
                        if (SKIP_DRAIN) begin
                            state       <= REDIRECT;
                            redir_valid <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (eret_bad) begin
                        eret_err <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state       <= REDIRECT;
                        redir_valid <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redir_ready) begin
                        state       <= IDLE;
                        redir_valid <= 1'b0;
                        stall       <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    redir_valid <= 1'b0;
                    stall       <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef ERET_CNT_EN
    // Completed-return counter, saturating at all ones.
    always_ff @(posedge clk) begin
        if (!reset)
            eret_count <= 32'd0;
        else if (hs && eret_count != 32'hFFFF_FFFF)
            eret_count <= eret_count + 32'd1;
    end
`endif

endmodule
